// File: rtl/clk_switch_pkg.sv
// Shared definitions for the clock-switch monitor: source codes, FSM encoding
// and the window-count classifier.
package clk_switch_pkg;

  localparam logic [1:0] SRC_STOP = 2'd0;
  localparam logic [1:0] SRC_A    = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;
  localparam logic [1:0] SRC_UNK  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StMeas,
    StReport
  } mon_state_e;

  // Ordered check: a zero count means stopped, and the clka range wins any overlap with clkb.
  function automatic logic [1:0] classify(input logic [31:0] cnt,
                                          input logic [31:0] a_min,
                                          input logic [31:0] a_max,
                                          input logic [31:0] b_min,
                                          input logic [31:0] b_max);
    if (cnt == 32'd0) begin
      return SRC_STOP;
    end else if (cnt >= a_min && cnt <= a_max) begin
      return SRC_A;
    end else if (cnt >= b_min && cnt <= b_max) begin
      return SRC_B;
    end
    return SRC_UNK;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_switch_mon.sv
// Counts rising edges of the switched clock over a fixed reference-clock window and
// classifies which source is driving it.
module clk_switch_mon
  import clk_switch_pkg::*;
#(
  parameter int unsigned WIN_CYC = 256,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned A_MIN   = 10,
  parameter int unsigned A_MAX   = 15,
  parameter int unsigned B_MIN   = 45,
  parameter int unsigned B_MAX   = 58
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_mon,
  output logic             meas_vld,
  output logic [CNT_W-1:0] meas_cnt,
  output logic [1:0]       src,
  output logic             stall,
  output logic             switch_evt
);

  localparam int unsigned WinW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic mon_sync;
  logic mon_dly_q;
  logic edge_det;

  mon_state_e       state_q, state_d;
  logic [WinW-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       src_new;
  logic             meas_vld_q, meas_vld_d;
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
  logic [1:0]       src_q, src_d;
  logic             stall_q, stall_d;
  logic             switch_evt_q, switch_evt_d;
  logic             first_q, first_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (clk_mon),
    .q_o (mon_sync)
  );

  assign edge_det = mon_sync & ~mon_dly_q;
  assign cnt_inc  = (edge_det && (edge_cnt_q != CntMax)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
  assign src_new  = classify(32'(cnt_inc), A_MIN, A_MAX, B_MIN, B_MAX);

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    meas_vld_d   = 1'b0;
    switch_evt_d = 1'b0;
    meas_cnt_d   = meas_cnt_q;
    src_d        = src_q;
    stall_d      = stall_q;
    first_d      = first_q;

    unique case (state_q)
      StIdle: begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        if (en) begin
          state_d = StMeas;
        end
      end
      StMeas: begin
        if (!en) begin
          // Abort silently: results from the previous window stay visible.
          state_d    = StIdle;
          win_cnt_d  = '0;
          edge_cnt_d = '0;
        end else if (win_cnt_q == WinLast) begin
          state_d      = StReport;
          win_cnt_d    = '0;
          edge_cnt_d   = '0;
          meas_vld_d   = 1'b1;
          meas_cnt_d   = cnt_inc;
          src_d        = src_new;
          stall_d      = (cnt_inc == '0);
          switch_evt_d = !first_q && (src_new != src_q);
          first_d      = 1'b0;
        end else begin
          win_cnt_d  = win_cnt_q + 1'b1;
          edge_cnt_d = cnt_inc;
        end
      end
      StReport: begin
        win_cnt_d = '0;
        // An edge seen during the report cycle belongs to the next window.
        if (en) begin
          state_d    = StMeas;
          edge_cnt_d = CNT_W'(edge_det);
        end else begin
          state_d    = StIdle;
          edge_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StIdle;
        win_cnt_d  = '0;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_dly_q    <= 1'b0;
      state_q      <= StIdle;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      meas_vld_q   <= 1'b0;
      meas_cnt_q   <= '0;
      src_q        <= SRC_STOP;
      stall_q      <= 1'b0;
      switch_evt_q <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      mon_dly_q    <= mon_sync;
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      meas_vld_q   <= meas_vld_d;
      meas_cnt_q   <= meas_cnt_d;
      src_q        <= src_d;
      stall_q      <= stall_d;
      switch_evt_q <= switch_evt_d;
      first_q      <= first_d;
    end
  end

  assign meas_vld   = meas_vld_q;
  assign meas_cnt   = meas_cnt_q;
  assign src        = src_q;
  assign stall      = stall_q;
  assign switch_evt = switch_evt_q;

endmodule

// File: tb/tb_clk_switch_mon.sv
// Scoreboard bench for clk_switch_mon. One time unit is 0.1 ns: clk period 2 ns,
// monitored clock generated in 1 ns steps offset half a step from clk edges.
module tb_clk_switch_mon;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             clk_mon = 1'b0;
  logic             meas_vld;
  logic [CNT_W-1:0] meas_cnt;
  logic [1:0]       src;
  logic             stall;
  logic             switch_evt;

  int half_ns = 20;
  int ph = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         id;
    int         lo;
    int         hi;
    logic [1:0] src;
    logic       stall;
    logic       evt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  clk_switch_mon #(
    .WIN_CYC (256),
    .CNT_W   (CNT_W),
    .A_MIN   (10),
    .A_MAX   (15),
    .B_MIN   (45),
    .B_MAX   (58)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clk_mon    (clk_mon),
    .meas_vld   (meas_vld),
    .meas_cnt   (meas_cnt),
    .src        (src),
    .stall      (stall),
    .switch_evt (switch_evt)
  );

  always #10 clk = ~clk;

  // Monitored clock: toggles every half_ns nanoseconds, held low when half_ns is 0.
  initial begin
    #5;
    forever begin
      #10;
      if (half_ns == 0) begin
        clk_mon = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= half_ns) begin
          ph = 0;
          clk_mon = ~clk_mon;
        end
      end
    end
  end

  function automatic void check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void check_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endfunction

  task automatic push(input int id, input int lo, input int hi, input logic [1:0] s,
                      input logic st, input logic ev);
    exp_t e;
    e.id = id; e.lo = lo; e.hi = hi; e.src = s; e.stall = st; e.evt = ev;
    exp_q.push_back(e);
  endtask

  task automatic skip(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Counts posedges until meas_vld is seen; a missing report is a failure.
  task automatic wait_vld(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!meas_vld && n < 2000);
    if (!meas_vld) begin
      n_chk++;
      n_fail++;
      $display("FAIL meas_vld_timeout: got no report within %0d cycles, expected one", n);
    end
  endtask

  // Monitor: compares every report against the oldest queued expectation.
  always begin
    @(posedge clk);
    #1;
    if (meas_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_meas_vld: got report cnt=%0d src=%0d, expected none",
                 meas_cnt, src);
      end else begin
        mon_e = exp_q.pop_front();
        check_rng($sformatf("win%0d_cnt", mon_e.id), int'(meas_cnt), mon_e.lo, mon_e.hi);
        check($sformatf("win%0d_src", mon_e.id), int'(src), int'(mon_e.src));
        check($sformatf("win%0d_stall", mon_e.id), int'(stall), int'(mon_e.stall));
        check($sformatf("win%0d_switch_evt", mon_e.id), int'(switch_evt), int'(mon_e.evt));
      end
    end
    if (switch_evt && !meas_vld) begin
      n_chk++;
      n_fail++;
      $display("FAIL switch_evt_without_vld: got switch_evt=1, expected 0");
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    skip(3);
    check("rst_meas_vld", int'(meas_vld), 0);
    check("rst_meas_cnt", int'(meas_cnt), 0);
    check("rst_src", int'(src), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_switch_evt", int'(switch_evt), 0);
    rst = 1'b0;

    // clka (40 ns) from reset; first window has no switch event.
    @(negedge clk);
    en = 1'b1;
    push(1, 12, 13, 2'd1, 1'b0, 1'b0);
    wait_vld(n);
    check("win1_latency", n, 257);

    // Switch to clkb (10 ns) just after a boundary.
    skip(10);
    half_ns = 5;
    push(2, 47, 52, 2'd2, 1'b0, 1'b1);
    wait_vld(n);
    push(3, 51, 52, 2'd2, 1'b0, 1'b0);
    wait_vld(n);
    check("steady_window_period", n, 257);

    // Stop the clock just before a boundary.
    push(4, 47, 52, 2'd2, 1'b0, 1'b0);
    skip(247);
    half_ns = 0;
    wait_vld(n);
    push(5, 0, 0, 2'd0, 1'b1, 1'b1);
    wait_vld(n);
    push(6, 0, 0, 2'd0, 1'b1, 1'b0);
    wait_vld(n);

    // 20 ns clock fits neither range.
    push(7, 23, 26, 2'd3, 1'b0, 1'b1);
    skip(10);
    half_ns = 10;
    wait_vld(n);
    push(8, 25, 26, 2'd3, 1'b0, 1'b0);
    wait_vld(n);

    // Abort mid-window: no report, results held.
    skip(100);
    en = 1'b0;
    skip(5);
    check("abort_meas_vld", int'(meas_vld), 0);
    check("abort_src_held", int'(src), 3);
    check("abort_stall_held", int'(stall), 0);
    check_rng("abort_cnt_held", int'(meas_cnt), 25, 26);
    en = 1'b1;
    push(9, 25, 26, 2'd3, 1'b0, 1'b0);
    wait_vld(n);
    check("reraise_latency", n, 257);

    // Asynchronous reset mid-window, then a fresh first window.
    skip(50);
    #2;
    rst = 1'b1;
    #2;
    check("arst_meas_vld", int'(meas_vld), 0);
    check("arst_meas_cnt", int'(meas_cnt), 0);
    check("arst_src", int'(src), 0);
    check("arst_stall", int'(stall), 0);
    check("arst_switch_evt", int'(switch_evt), 0);
    skip(3);
    rst = 1'b0;
    push(10, 25, 27, 2'd3, 1'b0, 1'b0);
    wait_vld(n);
    check("post_reset_latency", n, 257);

    skip(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
